// File: rtl/reg_file_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_burst_reader
//  Purpose  : Read-side sequencer for reg_file. On a start request it walks a
//             contiguous, wrapping range of register-file addresses and
//             streams the words out on a valid/ready interface, flagging the
//             final word of each burst.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    B          data width in bits (must match the reg_file instance)
//    W          address width      (must match the reg_file instance)
//  Ports
//    clk        in   1    single clock, rising edge
//    reset_n    in   1    asynchronous, active-low reset
//    start      in   1    burst request, sampled only in IDLE
//    base_addr  in   W    first address of the burst, sampled with start
//    len        in   W+1  number of words (0 allowed), sampled with start
//    r_addr     out  W    read address to reg_file
//    r_data     in   B    combinational read data from reg_file
//    dout       out  B    registered output word
//    dout_valid out  1    dout holds a word not yet accepted
//    dout_ready in   1    consumer accepts dout when high with dout_valid
//    dout_last  out  1    dout is the final word of the burst
//    busy       out  1    high in every state except IDLE
//    done_tick  out  1    one-cycle pulse at burst end
// ============================================================================
module reg_file_burst_reader #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] base_addr,
  input  logic [W:0]   len,
  output logic [W-1:0] r_addr,
  input  logic [B-1:0] r_data,
  output logic [B-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last,
  output logic         busy,
  output logic         done_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [W:0]   REM_ZERO  = '0;
  localparam logic [W:0]   REM_ONE   = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] ADDR_STEP = {{(W-1){1'b0}}, 1'b1};

  state_t         state;
  logic [W-1:0]   addr_reg;
  logic [W:0]     rem_reg;
  logic [B-1:0]   dout_reg;
  logic           dout_valid_reg;
  logic           dout_last_reg;

  // A word is consumed only when the consumer sees it valid.
  logic           handshake;
  assign handshake = dout_valid_reg & dout_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr_reg       <= '0;
      rem_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      dout_last_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != REM_ZERO) begin
              addr_reg <= base_addr;
              rem_reg  <= len;
              state    <= LOAD;
            end else begin
              // Empty burst: report completion without emitting a word.
              state <= DONE;
            end
          end
        end

        LOAD: begin
          // r_data is sampled before reg_file commits a same-edge write,
          // so a concurrent write to this address yields the old word.
          dout_reg       <= r_data;
          dout_valid_reg <= 1'b1;
          dout_last_reg  <= (rem_reg == REM_ONE);
          addr_reg       <= addr_reg + ADDR_STEP;
          rem_reg        <= rem_reg - REM_ONE;
          state          <= SEND;
        end

        SEND: begin
          if (handshake) begin
            if (rem_reg == REM_ZERO) begin
              dout_valid_reg <= 1'b0;
              dout_last_reg  <= 1'b0;
              state          <= DONE;
            end else begin
              // Back-to-back refill keeps one word per cycle.
              dout_reg       <= r_data;
              dout_valid_reg <= 1'b1;
              dout_last_reg  <= (rem_reg == REM_ONE);
              addr_reg       <= addr_reg + ADDR_STEP;
              rem_reg        <= rem_reg - REM_ONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign r_addr     = addr_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign dout_last  = dout_last_reg;
  assign busy       = (state != IDLE);
  assign done_tick  = (state == DONE);

endmodule
`default_nettype wire
